// File: rtl/sal_cfg_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sal_cfg_loader_pkg
//  Purpose  : Shared definitions for the DDR2 timing-register loader:
//             sequencer state encodings, failure-cause enum, APB constants
//             and the index -> timing-value table.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================

// DDR2 timing parameters in controller clock cycles. Guarded so a platform
// build can override them on the command line.
`ifndef DDR2_T_RCD
`define DDR2_T_RCD 5
`endif
`ifndef DDR2_T_RP
`define DDR2_T_RP  4
`endif
`ifndef DDR2_T_RAS
`define DDR2_T_RAS 15
`endif
`ifndef DDR2_T_RFC
`define DDR2_T_RFC 43
`endif
`ifndef DDR2_T_RTP
`define DDR2_T_RTP 3
`endif
`ifndef DDR2_T_WTP
`define DDR2_T_WTP 10
`endif
`ifndef DDR2_T_RRD
`define DDR2_T_RRD 6
`endif
`ifndef DDR2_T_CCD
`define DDR2_T_CCD 2
`endif
`ifndef DDR2_T_WTR
`define DDR2_T_WTR 8
`endif
`ifndef DDR2_T_RTW
`define DDR2_T_RTW 7
`endif

package sal_cfg_loader_pkg;

    localparam int          APB_DATA_W  = 32;
    localparam logic [31:0] ADDR_STRIDE = 32'd4;

    // Sequencer states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_NEXT   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_SLVERR   = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_MISMATCH = 2'd3
    } err_code_t;

    // Table order: T_RCD, T_RP, T_RAS, T_RFC, T_RTP, T_WTP, T_RRD, T_CCD,
    // T_WTR, T_RTW. Unused indices read as zero.
    function automatic logic [31:0] timing_value(input logic [3:0] idx);
        logic [31:0] v;
        case (idx)
            4'd0:    v = 32'(`DDR2_T_RCD);
            4'd1:    v = 32'(`DDR2_T_RP);
            4'd2:    v = 32'(`DDR2_T_RAS);
            4'd3:    v = 32'(`DDR2_T_RFC);
            4'd4:    v = 32'(`DDR2_T_RTP);
            4'd5:    v = 32'(`DDR2_T_WTP);
            4'd6:    v = 32'(`DDR2_T_RRD);
            4'd7:    v = 32'(`DDR2_T_CCD);
            4'd8:    v = 32'(`DDR2_T_WTR);
            4'd9:    v = 32'(`DDR2_T_RTW);
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sal_cfg_loader_apb_port.sv
`default_nettype none
// ============================================================================
//  Module   : sal_apb_master_port
//  Purpose  : Single-access APB master engine. A request is accepted when the
//             engine is idle or in the very cycle the current access
//             completes, so back-to-back accesses cost two cycles each.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             req, req_addr,
//             req_write, req_wdata - access request (one-cycle strobe)
//             ack                 - access completed (pready seen in ACCESS)
//             slverr              - completion carried pslverr
//             timeout             - TIMEOUT_CYC wait cycles expired
//             paddr..pwdata       - APB master outputs
//             pready, pslverr     - APB slave responses
//  Revision : 1.0 - initial release
// ============================================================================
module sal_apb_master_port
    import sal_cfg_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [31:0]           req_addr,
    input  logic                  req_write,
    input  logic [APB_DATA_W-1:0] req_wdata,
    output logic                  ack,
    output logic                  slverr,
    output logic                  timeout,
    output logic [31:0]           paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_DATA_W-1:0] pwdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_SETUP  = 2'd1;
    localparam logic [1:0] PH_ACCESS = 2'd2;

    localparam int              WAIT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    logic [1:0]        r_phase;
    logic [WAIT_W-1:0] r_wait;
    logic              w_in_access;
    logic              w_load;

    assign w_in_access = (r_phase == PH_ACCESS);
    assign ack         = w_in_access && pready;
    assign slverr      = ack && pslverr;
    // r_wait holds the number of stalled ACCESS cycles already seen, so the
    // TIMEOUT_CYC-th stalled cycle is the one that trips.
    assign timeout     = w_in_access && !pready && (r_wait == WAIT_LAST);
    assign w_load      = req && ((r_phase == PH_IDLE) || ack);

    assign psel        = (r_phase != PH_IDLE);
    assign penable     = w_in_access;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= PH_IDLE;
            r_wait  <= '0;
            paddr   <= '0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
        end else if (w_load) begin
            r_phase <= PH_SETUP;
            r_wait  <= '0;
            paddr   <= req_addr;
            pwrite  <= req_write;
            pwdata  <= req_wdata;
        end else begin
            case (r_phase)
                PH_SETUP: begin
                    r_phase <= PH_ACCESS;
                    r_wait  <= '0;
                end
                PH_ACCESS: begin
                    if (ack || timeout) begin
                        r_phase <= PH_IDLE;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                default: r_phase <= PH_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/sal_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module   : sal_cfg_loader
//  Purpose  : Programs NUM_REGS DDR2 timing registers over APB (address
//             4*i), then optionally reads every one back and compares.
//             Any slave error, timeout or read-back mismatch aborts the run
//             and records the first failing index and its cause.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             start                 - one-cycle pulse, accepted only in IDLE
//             paddr, psel, penable,
//             pwrite, pwdata        - APB master outputs
//             prdata, pready,
//             pslverr               - APB slave responses
//             busy                  - sequence in progress
//             done                  - one-cycle pulse at end of sequence
//             err, err_idx, err_code- result of the last sequence
//  Revision : 1.0 - initial release
// ============================================================================
module sal_cfg_loader
    import sal_cfg_loader_pkg::*;
#(
    parameter int NUM_REGS    = 10,
    parameter int TIMEOUT_CYC = 255,
    parameter int VERIFY_EN   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  err_idx,
    output logic [1:0]  err_code
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    logic [2:0]  r_state;
    logic [3:0]  r_idx;
    logic        r_read;
    logic        r_err;
    logic [3:0]  r_err_idx;
    err_code_t   r_err_code;

    logic        w_ack;
    logic        w_slverr;
    logic        w_timeout;
    logic        w_mismatch;
    logic        w_fail;
    logic        w_last;
    logic        w_req;
    logic [3:0]  w_nidx;
    logic        w_nread;
    logic [2:0]  w_state_nxt;
    logic [31:0] w_cmd_addr;
    logic [31:0] w_cmd_wdata;

    assign w_last      = (r_idx == LAST_IDX);
    assign w_mismatch  = w_ack && r_read && (prdata != timing_value(r_idx));
    assign w_fail      = w_slverr || w_timeout || w_mismatch;
    assign w_cmd_addr  = 32'(w_nidx) * ADDR_STRIDE;
    assign w_cmd_wdata = timing_value(w_nidx);

    // NEXT is a zero-cycle decision point: it is resolved in the same cycle
    // the access completes so the following SETUP starts immediately.
    always_comb begin
        w_req       = 1'b0;
        w_nidx      = r_idx;
        w_nread     = r_read;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_req       = 1'b1;
                    w_nidx      = '0;
                    w_nread     = 1'b0;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (w_fail) begin
                    w_state_nxt = ST_DONE;
                end else if (w_ack) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase

        if (w_state_nxt == ST_NEXT) begin
            if (!w_last) begin
                w_req       = 1'b1;
                w_nidx      = r_idx + 4'd1;
                w_state_nxt = ST_SETUP;
            end else if ((VERIFY_EN != 0) && !r_read) begin
                // Index wraps to 0 as the write pass hands over to read-back.
                w_req       = 1'b1;
                w_nidx      = '0;
                w_nread     = 1'b1;
                w_state_nxt = ST_SETUP;
            end else begin
                w_state_nxt = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_read     <= 1'b0;
            r_err      <= 1'b0;
            r_err_idx  <= '0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state <= w_state_nxt;
            if (w_req) begin
                r_idx  <= w_nidx;
                r_read <= w_nread;
            end
            if ((r_state == ST_IDLE) && start) begin
                r_err      <= 1'b0;
                r_err_idx  <= '0;
                r_err_code <= ERR_NONE;
            end else if ((r_state == ST_ACCESS) && w_fail) begin
                r_err     <= 1'b1;
                r_err_idx <= r_idx;
                if (w_timeout) begin
                    r_err_code <= ERR_TIMEOUT;
                end else if (w_slverr) begin
                    r_err_code <= ERR_SLVERR;
                end else begin
                    r_err_code <= ERR_MISMATCH;
                end
            end
        end
    end

    sal_apb_master_port #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_port (
        .clk       (clk),
        .rst       (rst),
        .req       (w_req),
        .req_addr  (w_cmd_addr),
        .req_write (!w_nread),
        .req_wdata (w_cmd_wdata),
        .ack       (w_ack),
        .slverr    (w_slverr),
        .timeout   (w_timeout),
        .paddr     (paddr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    assign busy     = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign done     = (r_state == ST_DONE);
    assign err      = r_err;
    assign err_idx  = r_err_idx;
    assign err_code = r_err_code;

endmodule

`default_nettype wire

// File: tb/tb_sal_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sal_cfg_loader
//  Purpose  : Self-checking bench for sal_cfg_loader with a reactive APB
//             slave model and an access scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sal_cfg_loader;

    localparam int NREG = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata = '0;
    logic        psel, penable, pwrite;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;
    logic        busy, done, err;
    logic [3:0]  err_idx;
    logic [1:0]  err_code;

    int tests = 0;
    int fails = 0;

    sal_cfg_loader #(
        .NUM_REGS    (NREG),
        .TIMEOUT_CYC (255),
        .VERIFY_EN   (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_idx  (err_idx),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    // Expected timing table: RCD, RP, RAS, RFC, RTP, WTP, RRD, CCD, WTR, RTW
    logic [31:0] tbl [NREG] = '{32'd5, 32'd4, 32'd15, 32'd43, 32'd3,
                                32'd10, 32'd6, 32'd2, 32'd8, 32'd7};

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } sb_ent_t;
    sb_ent_t sb_q[$];

    typedef struct {
        int waits;     // wait states inserted on every access
        int slv_idx;   // index answered with pslverr (-1 none)
        bit slv_rd;    // pslverr on the read pass instead of the write pass
        int bad_idx;   // read index answered with table+1 (-1 none)
        int hang_idx;  // read index never answered (-1 none)
        int n_acc;     // completed accesses expected
        int exp_done;  // cycle of the done pulse, start cycle = 0
        bit exp_err;
        int exp_idx;
        int exp_code;
    } vec_t;
    vec_t vecs[8];

    // Slave configuration and monitor state
    int          cfg_waits = 0, cfg_slv = -1, cfg_bad = -1, cfg_hang = -1;
    bit          cfg_slv_rd = 1'b0;
    logic [31:0] mem [16];
    logic [31:0] cap_addr = '0, cap_data = '0;
    logic        cap_wr = 1'b0;
    bit          unstable = 1'b0;
    int          wcnt = 0, stall_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic score_access();
        sb_ent_t e;
        if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL access: got unexpected access addr=%h wr=%b expected none", paddr, pwrite);
        end else begin
            e = sb_q.pop_front();
            check("access", {unstable, pwrite, paddr, pwrite ? pwdata : 32'd0},
                            {1'b0, e.wr, e.addr, e.wr ? e.data : 32'd0});
        end
    endtask

    // Reactive APB slave plus completion monitor
    initial begin
        int midx;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            if (psel && !penable) begin
                cap_addr  = paddr;
                cap_wr    = pwrite;
                cap_data  = pwdata;
                unstable  = 1'b0;
                wcnt      = 0;
                stall_cnt = 0;
            end
            if (psel && penable) begin
                if (paddr !== cap_addr || pwrite !== cap_wr || pwdata !== cap_data) unstable = 1'b1;
                midx = int'(paddr[5:2]);
                if (!(midx == cfg_hang && !pwrite) && wcnt == cfg_waits) begin
                    pready  = 1'b1;
                    pslverr = (midx == cfg_slv) && (pwrite != cfg_slv_rd);
                    prdata  = mem[midx] + ((!pwrite && midx == cfg_bad) ? 32'd1 : 32'd0);
                    if (pwrite) mem[midx] = pwdata;
                    score_access();
                end else begin
                    pready  = 1'b0;
                    pslverr = 1'b0;
                    wcnt++;
                    stall_cnt++;
                end
            end else begin
                pready  = 1'b0;
                pslverr = 1'b0;
            end
        end
    end

    task automatic push_expected(input int n);
        for (int k = 0; k < n; k++) begin
            sb_ent_t e;
            int i;
            i      = (k < NREG) ? k : k - NREG;
            e.addr = 32'(i * 4);
            e.wr   = (k < NREG);
            e.data = tbl[i];
            sb_q.push_back(e);
        end
    endtask

    task automatic run_seq(input vec_t v, input string tag);
        int cyc;
        cfg_waits  = v.waits;
        cfg_slv    = v.slv_idx;
        cfg_slv_rd = v.slv_rd;
        cfg_bad    = v.bad_idx;
        cfg_hang   = v.hang_idx;
        push_expected(v.n_acc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, " start_accept"}, {busy, err, err_idx, err_code}, {1'b1, 1'b0, 4'd0, 2'd0});
        // A start pulse mid-sequence must be ignored.
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 5);
        end
        start = 1'b0;
        check({tag, " done_cycle"}, cyc, v.exp_done);
        check({tag, " err_state"}, {err, err_idx, err_code},
              {v.exp_err, 4'(v.exp_idx), 2'(v.exp_code)});
        check({tag, " idle_at_done"}, {busy, psel, penable}, 3'b000);
        // start during the DONE cycle must be ignored too.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, " start_in_done"}, {busy, done, psel}, 3'b000);
        check({tag, " sb_empty"}, sb_q.size(), 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vec_t tv;
        int   cyc;
        int   ndone;

        //            waits slv rd bad hang n  done err idx code
        vecs[0] = '{0, -1, 1'b0, -1, -1, 20,  41, 1'b0, 0, 0};
        vecs[1] = '{3, -1, 1'b0, -1, -1, 20, 101, 1'b0, 0, 0};
        vecs[2] = '{0,  3, 1'b0, -1, -1,  4,   9, 1'b1, 3, 1};
        vecs[3] = '{1,  3, 1'b0, -1, -1,  4,  13, 1'b1, 3, 1};
        vecs[4] = '{0, -1, 1'b0,  7, -1, 18,  37, 1'b1, 7, 3};
        vecs[5] = '{2, -1, 1'b0,  0, -1, 11,  45, 1'b1, 0, 3};
        vecs[6] = '{0, -1, 1'b0, -1, -1, 20,  41, 1'b0, 0, 0};
        vecs[7] = '{0,  9, 1'b1, -1, -1, 20,  41, 1'b1, 9, 1};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state", {paddr, pwdata, psel, penable, pwrite, busy, done, err, err_idx, err_code}, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 8; r++) run_seq(vecs[r], $sformatf("vec%0d", r));

        // Read of index 5 never answered: 255 stalled ACCESS cycles.
        tv = '{0, -1, 1'b0, -1, 5, 15, 287, 1'b1, 5, 2};
        run_seq(tv, "timeout");
        check("timeout_stall", stall_cnt, 255);

        // Reset during the first ACCESS cycle of index 2 (3 wait states).
        cfg_waits = 3; cfg_slv = -1; cfg_bad = -1; cfg_hang = -1;
        push_expected(2);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_pre", {psel, penable, paddr}, {1'b1, 1'b1, 32'h8});
        rst = 1'b1;
        @(negedge clk);
        check("rst_outputs", {paddr, pwdata, psel, penable, pwrite, busy, done, err, err_idx, err_code}, '0);
        rst = 1'b0;
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("rst_no_done", ndone, 0);
        check("rst_sb_empty", sb_q.size(), 0);
        sb_q.delete();
        run_seq(vecs[0], "restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
